// File: rtl/data_mem_responder_if.sv
// Request/response channel between the MEM-stage initiator and the data-memory responder.
interface data_mem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one byte/half/word load or store per request, answered
// after a fixed LATENCY with sign/zero-extended load data or an error flag.
module data_mem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input logic                clock,
  input logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int         WORDS  = 2 ** (DM_ADDRESS - 2);
  localparam int         LANES  = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  req_ready_w;
  logic                  accept_w;
  logic                  enter_resp_w;
  logic                  commit_wr_w;
  logic                  acc_write_w;
  logic [2:0]            acc_funct3_w;
  logic [DM_ADDRESS-1:0] acc_addr_w;
  logic [DATA_W-1:0]     acc_wdata_w;
  logic                  acc_err_w;
  logic [LANES-1:0]      be_w;
  logic [DATA_W-1:0]     wlane_w;
  logic [DATA_W-1:0]     rd_word_w;
  logic                  rsp_err_w;

  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = lane[0];
      3'b010:  e = (lane != 2'b00);
      3'b100:  e = wr;
      3'b101:  e = wr | lane[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [1:0] lane,
                                                 input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] shifted;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req_ready_w = (state_q == ST_IDLE) && !reset;
  assign accept_w    = bus.req_valid && req_ready_w;

  // With LATENCY==1 the access commits on the accept edge, so use the live bus fields.
  assign acc_write_w  = (state_q == ST_IDLE) ? bus.req_write  : write_q;
  assign acc_funct3_w = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
  assign acc_addr_w   = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
  assign acc_wdata_w  = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
  assign acc_err_w    = access_err(acc_write_w, acc_funct3_w, acc_addr_w[1:0]);

  assign enter_resp_w = !reset &&
                        (((state_q == ST_IDLE) && accept_w && (LATENCY == 1)) ||
                         ((state_q == ST_WAIT) && (cnt_q == 4'd1)));
  assign commit_wr_w  = enter_resp_w && acc_write_w && !acc_err_w;

  always_comb begin
    be_w    = '0;
    wlane_w = acc_wdata_w;
    case (acc_funct3_w[1:0])
      2'b00: begin
        be_w    = 4'b0001 << acc_addr_w[1:0];
        wlane_w = {4{acc_wdata_w[7:0]}};
      end
      2'b01: begin
        be_w    = acc_addr_w[1] ? 4'b1100 : 4'b0011;
        wlane_w = {2{acc_wdata_w[15:0]}};
      end
      default: be_w = 4'b1111;
    endcase
  end

  // One RAM per byte lane gives clean byte-enable block RAM inference.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem_q [WORDS];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clock) begin
        if (commit_wr_w && be_w[gi]) begin
          lane_mem_q[acc_addr_w[DM_ADDRESS-1:2]] <= wlane_w[8*gi +: 8];
        end
        if (enter_resp_w) begin
          lane_rd_q <= lane_mem_q[acc_addr_w[DM_ADDRESS-1:2]];
        end
      end

      assign rd_word_w[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept_w) begin
      write_q  <= bus.req_write;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

  // Outputs only depend on registers that are frozen while in RESP.
  assign rsp_err_w     = (state_q == ST_RESP) && access_err(write_q, funct3_q, addr_q[1:0]);
  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = rsp_err_w;
  assign bus.rsp_rdata = ((state_q == ST_RESP) && !write_q && !rsp_err_w)
                         ? load_ext(funct3_q, addr_q[1:0], rd_word_w) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=3 instance for the reset-during-wait scenario.
module tb_data_mem_responder;

  localparam int AW = 9;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_err;
  logic [31:0] obs_rsp_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  data_mem_responder_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus2 ();
  data_mem_responder_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus3 ();

  assign bus2.req_valid  = req_valid && !sel;
  assign bus3.req_valid  = req_valid && sel;
  assign bus2.req_write  = req_write;
  assign bus3.req_write  = req_write;
  assign bus2.req_funct3 = req_funct3;
  assign bus3.req_funct3 = req_funct3;
  assign bus2.req_addr   = req_addr;
  assign bus3.req_addr   = req_addr;
  assign bus2.req_wdata  = req_wdata;
  assign bus3.req_wdata  = req_wdata;
  assign bus2.rsp_ready  = rsp_ready;
  assign bus3.rsp_ready  = rsp_ready;

  assign obs_req_ready = sel ? bus3.req_ready : bus2.req_ready;
  assign obs_rsp_valid = sel ? bus3.rsp_valid : bus2.rsp_valid;
  assign obs_rsp_err   = sel ? bus3.rsp_err   : bus2.rsp_err;
  assign obs_rsp_rdata = sel ? bus3.rsp_rdata : bus2.rsp_rdata;

  data_mem_responder #(.DM_ADDRESS(AW), .DATA_W(32), .LATENCY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  data_mem_responder #(.DM_ADDRESS(AW), .DATA_W(32), .LATENCY(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!obs_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("req_ready_wait", 32'(obs_req_ready), 32'd1);
  endtask

  // Issue one request, hold the response for 'hold' cycles, then complete it.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                        input int hold);
    int   cyc;
    int   lat;
    exp_t e;
    lat = sel ? 3 : 2;
    @(negedge clock);
    wait_ready();
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clock);
    sb_q.push_back('{rdata: exp_d, err: exp_e});
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wd;
    cyc = 1;
    while (!obs_rsp_valid && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("rsp_latency", 32'(cyc), 32'(lat));
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("rsp_rdata", obs_rsp_rdata, e.rdata);
    check_eq("rsp_err", 32'(obs_rsp_err), 32'(e.err));
    $display("txn wr=%0d f3=%03b addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             wr, f3, addr, wd, obs_rsp_rdata, obs_rsp_err, cyc);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 9'h000;
      end
      @(negedge clock);
      req_valid = 1'b0;
      check_eq("hold_valid", 32'(obs_rsp_valid), 32'd1);
      check_eq("hold_rdata", obs_rsp_rdata, e.rdata);
      check_eq("hold_err", 32'(obs_rsp_err), 32'(e.err));
      check_eq("hold_ready", 32'(obs_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    check_eq("post_valid", 32'(obs_rsp_valid), 32'd0);
    check_eq("post_ready", 32'(obs_req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clock);
    check_eq("rst_req_ready", 32'(obs_req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(obs_rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", obs_rsp_rdata, 32'd0);
    reset = 1'b0;

    do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    do_req(1'b0, 3'b100, 9'h013, 32'h0, 32'h000000DE, 1'b0, 0);
    do_req(1'b0, 3'b001, 9'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    do_req(1'b0, 3'b101, 9'h010, 32'h0, 32'h0000BEEF, 1'b0, 0);
    do_req(1'b1, 3'b000, 9'h011, 32'h12345655, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    do_req(1'b1, 3'b001, 9'h012, 32'h0000CAFE, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, 32'hCAFE55EF, 1'b0, 0);
    do_req(1'b0, 3'b010, 9'h012, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b1, 3'b001, 9'h011, 32'h0000FFFF, 32'h0, 1'b1, 0);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, 32'hCAFE55EF, 1'b0, 0);
    do_req(1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b0, 3'b010, 9'h010, 32'h0, 32'hCAFE55EF, 1'b0, 3);

    // The req_valid pulse during backpressure must not spawn a response.
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (obs_rsp_valid) seen = 1;
    end
    check_eq("ignored_pulse", 32'(seen), 32'd0);

    sel = 1'b1;
    do_req(1'b1, 3'b010, 9'h020, 32'h11223344, 32'h0, 1'b0, 0);
    @(negedge clock);
    wait_ready();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 9'h020;
    req_wdata  = 32'hA5A5A5A5;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(obs_req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      if (obs_rsp_valid) seen = 1;
      @(negedge clock);
    end
    check_eq("mid_rst_no_rsp", 32'(seen), 32'd0);
    do_req(1'b0, 3'b010, 9'h020, 32'h0, 32'h11223344, 1'b0, 0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the MEM stage of the five-stage RISC-V pipeline. The MEM stage acts as the request initiator.
- Accepts one load/store request per valid/ready handshake and performs a byte/halfword/word access to a local byte-addressed RAM.
- Returns load data (sign/zero extended per funct3), or an error flag, on a response channel after a fixed, parameterised latency.
- The pipeline stalls on `req_ready` low or on the response not yet valid.

Parameters:
- DM_ADDRESS, 9, byte-address width; RAM holds 2**DM_ADDRESS bytes, organised as 2**(DM_ADDRESS-2) 32-bit words.
- DATA_W, 32, data width; fixed at 32.
- LATENCY, 2, cycles from request acceptance edge to first `rsp_valid` cycle; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (access size/sign).
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data; low bytes used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  illegal funct3 or misaligned access.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. `req_ready`=0 while `reset` is high. RAM contents are not cleared.
- State IDLE:
  - req_ready=1.
  - On a clock edge with req_valid&&req_ready, latch write, funct3, addr and wdata.
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY==1, else go to WAIT.
- State WAIT:
  - req_ready=0; decrement counter each edge.
  - On the edge where counter==1, go to RESP.
- Access commit: the RAM write or read happens on the edge that enters RESP. rsp_valid is therefore first high exactly LATENCY cycles after the accept edge.
- State RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready on an edge; then go to IDLE and clear rsp_valid.
  - No request is accepted in the same cycle as the response handshake. Maximum throughput is one request per LATENCY+1 cycles.
- Byte lanes are little-endian: lane = addr[1:0] within word addr[DM_ADDRESS-1:2].
- Loads:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword at lane addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
- Stores (byte-enable write; other lanes unchanged):
  - 000 SB: wdata[7:0].
  - 001 SH: wdata[15:0].
  - 010 SW: full word.
- Errors:
  - Any other funct3 sets rsp_err=1.
  - Halfword access with addr[0]=1 sets rsp_err=1.
  - Word access with addr[1:0]!=0 sets rsp_err=1.
  - On error: no RAM write, rsp_rdata=0, response still delivered with normal latency.
- Boundaries:
  - req_valid, funct3, addr and wdata changes while not in IDLE are ignored; the latched values are used.
  - Address is confined to DM_ADDRESS bits; there is no wrap or out-of-range case.
- Reset mid-operation:
  - In WAIT: the pending request is dropped and a store is not committed.
  - In RESP: the response is discarded.
  - In both cases the next state is IDLE with outputs at reset values.

Test Plan:
1. Word round trip: SW addr 0x010, data 0xDEADBEEF, LATENCY=2 -> rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0. Then LW 0x010 -> rsp_rdata=0xDEADBEEF.
2. Load extensions on the word from scenario 1:
   - LB 0x013 -> 0xFFFFFFDE.
   - LBU 0x013 -> 0x000000DE.
   - LH 0x012 -> 0xFFFFDEAD.
   - LHU 0x010 -> 0x0000BEEF.
3. Sub-word stores: SB 0x011, wdata 0x12345655, then LW 0x010 -> 0xDEAD55EF. SH 0x012, wdata 0x0000CAFE, then LW 0x010 -> 0xCAFE55EF.
4. Errors:
   - LW 0x012 -> rsp_err=1, rsp_rdata=0.
   - SH 0x011, wdata 0xFFFF -> rsp_err=1; a following LW 0x010 still returns 0xCAFE55EF.
   - funct3=011 -> rsp_err=1.
5. Backpressure: hold rsp_ready=0 for 3 cycles during an LW response -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0. A second req_valid pulse is ignored. After rsp_ready=1, one handshake occurs and req_ready returns to 1 next cycle.
6. Reset mid-operation: SW 0x020, data 0xA5A5A5A5, with LATENCY=3; assert reset for one cycle during WAIT -> rsp_valid never asserts. A subsequent LW 0x020 returns the prior contents of 0x020, not 0xA5A5A5A5.
